// File: rtl/fmul_arb.sv
// fmul_arb: two-port arbiter sharing one multiplier, with timeout and qNaN substitution
module fmul_arb #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_y,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_y,
  input  logic        rsp1_ready,
  output logic [31:0] mul_x1,
  output logic [31:0] mul_x2,
  output logic        mul_ready,
  input  logic [31:0] mul_y,
  input  logic        mul_valid,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state, nxt;
  logic        ptr, owner, hs, active, tmo, rsp_hs;
  logic [7:0]  cnt;
  logic [31:0] x1_q, x2_q, res_q;
  assign req0_ready = !rst && state == S_IDLE && req0_valid && (!req1_valid || !ptr);
  assign req1_ready = !rst && state == S_IDLE && req1_valid && (!req0_valid || ptr);
  assign hs     = req0_ready || req1_ready;
  assign active = state == S_ISSUE || state == S_WAIT;
  assign tmo    = active && !mul_valid && cnt == 8'(MAX_WAIT - 1);
  assign rsp_hs = state == S_RESP && (owner ? rsp1_ready : rsp0_ready);
  // state register
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : nxt;
  // next-state: result or timeout ends the wait, consumer handshake ends the response
  always_comb begin
    nxt = state;
    if (state == S_IDLE) nxt = hs ? S_ISSUE : S_IDLE;
    else if (active) nxt = (mul_valid || tmo) ? S_RESP : S_WAIT;
    else nxt = rsp_hs ? S_IDLE : S_RESP;
  end
  // outputs decoded from state; results are only exposed to the owner while in RESP
  always_comb begin
    mul_ready  = state == S_ISSUE;
    busy       = state != S_IDLE;
    rsp0_valid = state == S_RESP && !owner;
    rsp1_valid = state == S_RESP && owner;
    rsp0_y     = rsp0_valid ? res_q : 32'h0;
    rsp1_y     = rsp1_valid ? res_q : 32'h0;
    mul_x1     = x1_q;
    mul_x2     = x2_q;
  end
  // operand capture, round-robin pointer, wait counter, result and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
      x1_q  <= 32'h0;
      x2_q  <= 32'h0;
      res_q <= 32'h0;
      cnt   <= 8'h0;
      err   <= 1'b0;
    end else begin
      if (hs) begin
        x1_q  <= req1_ready ? req1_x1 : req0_x1;
        x2_q  <= req1_ready ? req1_x2 : req0_x2;
        owner <= req1_ready;
        ptr   <= !req1_ready;
        cnt   <= 8'h0;
      end
      if (active) begin
        if (mul_valid) res_q <= mul_y;
        else if (tmo) begin
          res_q <= 32'h7FC00000;
          err   <= 1'b1;
        end else cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_fmul_arb.sv
// tb_fmul_arb: randomized timeline-based reference check of fmul_arb
module tb_fmul_arb;
  localparam int MW = 15;
  localparam int NEVER = 32'h3fffffff;
  logic clk = 1'b0, rst;
  logic req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req0_x1, req0_x2, rsp0_y, req1_x1, req1_x2, rsp1_y;
  logic [31:0] mul_x1, mul_x2, mul_y;
  logic mul_ready, mul_valid, busy, err;
  int checks = 0, errors = 0;
  fmul_arb #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y), .rsp1_ready(rsp1_ready),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_ready(mul_ready), .mul_y(mul_y),
    .mul_valid(mul_valid), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  bit m_busy, m_owner, m_ptr;
  logic [31:0] m_x1, m_x2, m_y, m_res;
  int m_hs, m_d, m_resp, m_errc;
  initial begin
    bit in_resp, quiet, fire, e_r0, e_r1, e_v0, e_v1;
    int r;
    rst = 1'b1;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready, mul_valid} = '0;
    {req0_x1, req0_x2, req1_x1, req1_x2, mul_y} = '0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_x1 = 0; m_x2 = 0; m_y = 0; m_res = 0;
    m_hs = 0; m_d = 0; m_resp = 0; m_errc = NEVER;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      rst = (c < 2) || ($urandom_range(99) == 0);
      req0_valid = $urandom_range(3) != 0;
      req1_valid = $urandom_range(3) != 0;
      req0_x1 = $urandom; req0_x2 = $urandom;
      req1_x1 = $urandom; req1_x2 = $urandom;
      rsp0_ready = $urandom_range(2) != 0;
      rsp1_ready = $urandom_range(2) != 0;
      in_resp = m_busy && c >= m_resp;
      quiet = !m_busy || in_resp;
      fire = !quiet && c == m_hs + 1 + m_d;
      mul_valid = quiet ? 1'($urandom_range(1)) : fire;
      mul_y = fire ? m_y : $urandom;
      @(negedge clk);
      e_r0 = !rst && !m_busy && req0_valid && (!req1_valid || !m_ptr);
      e_r1 = !rst && !m_busy && req1_valid && (!req0_valid || m_ptr);
      e_v0 = in_resp && !m_owner;
      e_v1 = in_resp && m_owner;
      if (c > 0) begin
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("mul_ready", mul_ready, m_busy && c == m_hs + 1);
        check("busy", busy, m_busy);
        check("rsp0_valid", rsp0_valid, e_v0);
        check("rsp1_valid", rsp1_valid, e_v1);
        check("rsp0_y", rsp0_y, e_v0 ? m_res : 32'h0);
        check("rsp1_y", rsp1_y, e_v1 ? m_res : 32'h0);
        check("mul_x1", mul_x1, m_x1);
        check("mul_x2", mul_x2, m_x2);
        check("err", err, c >= m_errc);
      end
      if (rst) begin
        m_busy = 0; m_ptr = 0; m_owner = 0; m_x1 = 0; m_x2 = 0; m_errc = NEVER;
      end else if (in_resp && (m_owner ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
      end else if (e_r0 || e_r1) begin
        m_busy = 1;
        m_owner = e_r1;
        m_ptr = !e_r1;
        m_x1 = e_r1 ? req1_x1 : req0_x1;
        m_x2 = e_r1 ? req1_x2 : req0_x2;
        m_hs = c;
        r = $urandom_range(9);
        m_d = r < 4 ? 0 : r < 7 ? int'($urandom_range(5, 1)) : r == 7 ? MW - 1 : r == 8 ? MW : 99;
        m_y = $urandom;
        if (m_d < MW) begin
          m_resp = c + 2 + m_d;
          m_res = m_y;
        end else begin
          m_resp = c + 1 + MW;
          m_res = 32'h7FC00000;
          if (m_errc > m_resp) m_errc = m_resp;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fmul_arb.md
FMUL_ARB -- requirements
Module: fmul_arb

Interface
REQ-001 Parameter: MAX_WAIT, default 15, number of cycles the block waits for mul_valid after issue before timing out (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  port 0 has an operation pending.
REQ-005 req0_x1, req0_x2  input  32 each  port 0 IEEE-754 single operands.
REQ-006 req0_ready  output  1  port 0 operands accepted this cycle.
REQ-007 rsp0_valid  output  1  port 0 result available.
REQ-008 rsp0_y  output  32  port 0 result.
REQ-009 rsp0_ready  input  1  port 0 consumes the result.
REQ-010 req1_valid, req1_x1, req1_x2, req1_ready, rsp1_valid, rsp1_y, rsp1_ready: same as port 0, for port 1.
REQ-011 mul_x1, mul_x2  output  32 each  operands to the shared multiplier.
REQ-012 mul_ready  output  1  operation start strobe to the multiplier.
REQ-013 mul_y  input  32  multiplier result.
REQ-014 mul_valid  input  1  multiplier result valid; it may be asserted combinationally in the same cycle as mul_ready.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, and exactly one operation SHALL be outstanding at a time.
REQ-018 Arbitration in IDLE SHALL use the following rules:
- Only one reqN_valid high: grant that port.
- Both high: grant the port named by the priority pointer.
- Neither high: stay in IDLE.
REQ-019 reqN_ready SHALL be combinational and high only in IDLE, for the granted port only; a handshake occurs when reqN_valid and reqN_ready are both high.
REQ-020 On a handshake the block SHALL:
- register the operands and the owner tag;
- set the priority pointer to the other port;
- move to ISSUE.
REQ-021 mul_x1 and mul_x2 SHALL be driven from the operand registers, holding their values through ISSUE and WAIT.
REQ-022 mul_ready SHALL be high for exactly one cycle, in ISSUE, and low in every other state.
REQ-023 In ISSUE or WAIT, the first cycle with mul_valid high SHALL capture mul_y into the result register and move to RESP; from ISSUE without mul_valid the FSM SHALL go to WAIT.
REQ-024 The wait counter SHALL behave as follows:
- clear on entry to ISSUE;
- increment each cycle spent in ISSUE or WAIT without mul_valid;
- on reaching MAX_WAIT, set err, load 32'h7FC00000 (qNaN) into the result register, and move to RESP.
REQ-025 mul_valid SHALL be ignored in IDLE and RESP.
REQ-026 In RESP, rspN_valid SHALL be high for the owner port only, with rspN_y equal to the result register.
REQ-027 The result SHALL be held stable in RESP until rspN_ready is high; in that cycle the FSM SHALL return to IDLE.
REQ-028 No new request SHALL be accepted in the same cycle as the RESP handshake.
REQ-029 The non-owner rsp valid SHALL be 0 at all times; rspN_ready SHALL be ignored when rspN_valid is low.
REQ-030 Latency with a combinational multiplier SHALL be 2 cycles: handshake in cycle 0, ISSUE in cycle 1, rsp valid in cycle 2.
REQ-031 Throughput SHALL be at most one operation per 3 cycles.
REQ-032 err SHALL stay high until reset.
REQ-033 The block SHALL NOT modify operand or result bits other than by substituting the timeout value.

Reset
REQ-034 While rst is high at a clock edge, the block SHALL:
- set the FSM to IDLE;
- set the priority pointer to port 0;
- clear err, the wait counter, the operand, result and tag registers;
- drop any in-flight operation without a response.
REQ-035 During and after reset, all outputs SHALL be 0 (req*_ready, rsp*_valid, rsp*_y, mul_ready, mul_x*, busy, err) until the next handshake.
REQ-036 A request held high across reset deassertion SHALL be granted in the first cycle after reset, subject to REQ-018.

Verification
REQ-037 Port 0 request 3F800000 x 40000000, multiplier returning combinationally -> req0_ready cycle 0, mul_ready cycle 1, rsp0_valid with rsp0_y=40000000 in cycle 2; rsp1_valid stays 0.
REQ-038 Both ports valid continuously with rsp ready tied high -> grants alternate 0,1,0,1 starting with port 0; each grant follows 3 cycles after the previous one.
REQ-039 Multiplier model delays mul_valid 4 cycles -> mul_ready is a single pulse; mul_x1 and mul_x2 stay stable; rsp arrives 4 cycles later than in REQ-037; err=0.
REQ-040 mul_valid never asserted, MAX_WAIT=15 -> after 15 cycles rsp_y=7FC00000 and err=1; err stays 1 after the response is consumed.
REQ-041 rsp1_ready held low for 10 cycles in RESP -> rsp1_y stable; req0 pending is not granted until the cycle after rsp1_ready rises.
REQ-042 rst asserted in WAIT -> next cycle all outputs are 0 and the FSM is in IDLE; the old result never appears; the following grant goes to port 0 when both ports request.
